// File: rtl/direction_controller_if.sv
// Bundle of the controller's run, button and heading/strobe signals.
// No latency of its own; it carries wires only.
// No backpressure: the buttons are raw levels and the strobes are one-cycle pulses.
interface direction_controller_if;
    logic       enable;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [1:0] direction;
    logic       move_tick;
    logic       turn_event;

    modport master (
        output enable, btn_up, btn_down, btn_left, btn_right,
        input  direction, move_tick, turn_event
    );

    modport slave (
        input  enable, btn_up, btn_down, btn_left, btn_right,
        output direction, move_tick, turn_event
    );
endinterface

// File: rtl/direction_controller.sv
// Turns raw buttons into a registered heading and a periodic move strobe; turns commit only on a strobe.
// A button is acted on 2 edges after it is first sampled high; the strobe follows terminal count by one edge.
// No backpressure: the consumer must take every move_tick, and enable low freezes motion.
module direction_controller #(
    parameter int unsigned TICK_DIV = 833333,
    parameter logic [1:0]  INIT_DIR = 2'b01
) (
    input logic                   CLOCK_50,
    input logic                   reset,
    direction_controller_if.slave ctrl
);
    localparam logic [19:0] TERM      = 20'(TICK_DIV - 1);
    localparam logic [1:0]  DIR_DOWN  = 2'b00;
    localparam logic [1:0]  DIR_RIGHT = 2'b01;
    localparam logic [1:0]  DIR_UP    = 2'b10;
    localparam logic [1:0]  DIR_LEFT  = 2'b11;

    // Button vectors are ordered {up, down, left, right}, i.e. highest priority in the MSB.
    logic [3:0]  btn_raw;
    logic [3:0]  btn_s1;
    logic [3:0]  btn_s2;
    logic [3:0]  btn_prev;
    logic [3:0]  btn_rise;
    logic [19:0] tick_cnt;
    logic        pending_valid;
    logic [1:0]  pending_dir;
    logic [1:0]  dir_q;
    logic        move_tick_q;
    logic        turn_event_q;
    logic        terminal;
    logic        req_vld;
    logic [1:0]  req_dir;
    logic [1:0]  ref_dir;
    logic        req_ok;

    assign btn_raw  = {ctrl.btn_up, ctrl.btn_down, ctrl.btn_left, ctrl.btn_right};
    assign btn_rise = btn_s2 & ~btn_prev;
    assign terminal = ctrl.enable && (tick_cnt == TERM);

    // Keep only the highest-priority new press; anything pressed alongside it is dropped.
    always_comb begin
        req_vld = 1'b1;
        req_dir = DIR_DOWN;
        if (btn_rise[3])      req_dir = DIR_UP;
        else if (btn_rise[2]) req_dir = DIR_DOWN;
        else if (btn_rise[1]) req_dir = DIR_LEFT;
        else if (btn_rise[0]) req_dir = DIR_RIGHT;
        else                  req_vld = 1'b0;
    end

    // On a commit edge the request is judged against the heading being committed, not the old one.
    assign ref_dir = (terminal && pending_valid) ? pending_dir : dir_q;
    assign req_ok  = req_vld && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b10));

    // Synchronizers, step counter, pending-turn buffer and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            btn_s1        <= '0;
            btn_s2        <= '0;
            btn_prev      <= '0;
            tick_cnt      <= '0;
            pending_valid <= 1'b0;
            pending_dir   <= 2'b00;
            dir_q         <= INIT_DIR;
            move_tick_q   <= 1'b0;
            turn_event_q  <= 1'b0;
        end else begin
            // Synchronizers keep running while disabled so no stale edge appears on re-enable.
            btn_s1       <= btn_raw;
            btn_s2       <= btn_s1;
            btn_prev     <= btn_s2;
            move_tick_q  <= 1'b0;
            turn_event_q <= 1'b0;
            if (!ctrl.enable) begin
                tick_cnt      <= '0;
                pending_valid <= 1'b0;
            end else begin
                if (terminal) begin
                    tick_cnt    <= '0;
                    move_tick_q <= 1'b1;
                    if (pending_valid) begin
                        dir_q        <= pending_dir;
                        turn_event_q <= 1'b1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + 20'd1;
                end
                if (req_ok) begin
                    pending_dir   <= req_dir;
                    pending_valid <= 1'b1;
                end else if (terminal) begin
                    pending_valid <= 1'b0;
                end
            end
        end
    end

    assign ctrl.direction  = dir_q;
    assign ctrl.move_tick  = move_tick_q;
    assign ctrl.turn_event = turn_event_q;
endmodule

// File: tb/tb_direction_controller.sv
// Bench for direction_controller: vector table, hand-timed corner sequences, random run against a reference model.
// Outputs are sampled 1 time unit after each rising edge.
// No backpressure involved; inputs change only between edges.
module tb_direction_controller;
    localparam int unsigned TD   = 4;
    localparam logic [1:0]  INIT = 2'b01;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    direction_controller_if ifc();

    direction_controller #(.TICK_DIV(TD), .INIT_DIR(INIT)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .ctrl     (ifc)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad = 0;
    int turn_cnt = 0;

    // Reference model: a press is seen two edges after it is sampled, steps come every TD enabled edges.
    logic [3:0] h0, h1, h2;
    int         run_edges;
    logic       m_pend;
    logic [1:0] m_pdir;
    logic [1:0] m_dir;
    logic       m_tick;
    logic       m_turn;

    function automatic logic [1:0] pick(input logic [3:0] rise);
        if (rise[3]) return 2'b10;
        if (rise[2]) return 2'b00;
        if (rise[1]) return 2'b11;
        return 2'b01;
    endfunction

    function automatic void model_edge(input logic rst, input logic en, input logic [3:0] btn);
        logic [3:0] rise;
        logic [1:0] req;
        if (rst) begin
            h0 = '0; h1 = '0; h2 = '0;
            run_edges = 0; m_pend = 0; m_pdir = 2'b00;
            m_dir = INIT; m_tick = 0; m_turn = 0;
            return;
        end
        rise = h1 & ~h2;
        h2 = h1; h1 = h0; h0 = btn;
        m_tick = 0; m_turn = 0;
        if (!en) begin
            run_edges = 0;
            m_pend = 0;
            return;
        end
        run_edges++;
        if (run_edges % TD == 0) begin
            m_tick = 1;
            if (m_pend) begin
                m_dir = m_pdir;
                m_turn = 1;
                m_pend = 0;
            end
        end
        if (rise != 0) begin
            req = pick(rise);
            if (req != m_dir && req != (m_dir ^ 2'b10)) begin
                m_pend = 1;
                m_pdir = req;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        ifc.btn_up    = b[3];
        ifc.btn_down  = b[2];
        ifc.btn_left  = b[1];
        ifc.btn_right = b[0];
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        @(posedge CLOCK_50);
        model_edge(reset, ifc.enable, {ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right});
        #1;
        chk("model", {ifc.direction, ifc.move_tick, ifc.turn_event}, {m_dir, m_tick, m_turn});
        if (ifc.turn_event) turn_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Two reset edges; the next edge is the first of a fresh step.
    task automatic do_reset();
        set_btn(4'b0000);
        ifc.enable = 1'b1;
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] btn;
        logic [1:0] dir;
        logic       tick;
        logic       turn;
    } vec_t;

    vec_t tbl[23];
    int   t0;

    initial begin
        set_btn(4'b0000);
        ifc.enable = 1'b1;

        // Per-edge vectors: idle ticks, up pulse committing on a tick, held reversal ignored.
        tbl[0]  = '{1'b1, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'b1000, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0};

        for (int i = 0; i < 23; i++) begin
            reset = tbl[i].rst;
            ifc.enable = tbl[i].en;
            set_btn(tbl[i].btn);
            step();
            chk($sformatf("vec%0d", i), {ifc.direction, ifc.move_tick, ifc.turn_event},
                {tbl[i].dir, tbl[i].tick, tbl[i].turn});
        end

        // Reversal from heading right is discarded.
        do_reset();
        t0 = turn_cnt;
        set_btn(4'b0010); step(); set_btn(4'b0000);
        steps(7);
        chk("rev_dir", ifc.direction, 2'b01);
        chk("rev_turns", turn_cnt - t0, 0);

        // Up and down together: up wins and commits; a later down is a reversal of up.
        do_reset();
        set_btn(4'b1100); step(); set_btn(4'b0000);
        steps(3);
        chk("prio_commit", {ifc.direction, ifc.move_tick, ifc.turn_event}, {2'b10, 1'b1, 1'b1});
        set_btn(4'b0100); step(); set_btn(4'b0000);
        steps(3);
        chk("prio_rev", {ifc.direction, ifc.move_tick, ifc.turn_event}, {2'b10, 1'b1, 1'b0});

        // Up then down inside one step: the newer request overwrites.
        do_reset();
        steps(2);
        set_btn(4'b1000); step();
        set_btn(4'b0100); step();
        set_btn(4'b0000);
        chk("ovw_first_tick", {ifc.direction, ifc.move_tick}, {2'b01, 1'b1});
        steps(4);
        chk("ovw_commit", {ifc.direction, ifc.move_tick, ifc.turn_event}, {2'b00, 1'b1, 1'b1});

        // Reset with a turn pending drops it.
        do_reset();
        t0 = turn_cnt;
        set_btn(4'b1000); step(); set_btn(4'b0000);
        steps(2);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_dir", ifc.direction, INIT);
        steps(8);
        chk("rst_dir_later", ifc.direction, INIT);
        chk("rst_turns", turn_cnt - t0, 0);

        // Enable low with a turn pending drops it; heading is held.
        do_reset();
        t0 = turn_cnt;
        set_btn(4'b1000); step(); set_btn(4'b0000);
        steps(2);
        ifc.enable = 1'b0; steps(3);
        chk("dis_tick", ifc.move_tick, 0);
        ifc.enable = 1'b1;
        steps(8);
        chk("dis_dir", ifc.direction, 2'b01);
        chk("dis_turns", turn_cnt - t0, 0);

        // Up held for 12 edges yields a single request even after the heading moves away from up.
        do_reset();
        t0 = turn_cnt;
        set_btn(4'b1000);
        steps(4);
        chk("hold_first", ifc.direction, 2'b10);
        set_btn(4'b1001); step(); set_btn(4'b1000);
        steps(7);
        set_btn(4'b0000);
        steps(4);
        chk("hold_dir", ifc.direction, 2'b01);
        chk("hold_turns", turn_cnt - t0, 2);

        // Random buttons, occasional enable drops and resets against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) ifc.enable = ~ifc.enable;
            if ($urandom_range(0, 7) == 0) ifc.btn_up    = ~ifc.btn_up;
            if ($urandom_range(0, 7) == 0) ifc.btn_down  = ~ifc.btn_down;
            if ($urandom_range(0, 7) == 0) ifc.btn_left  = ~ifc.btn_left;
            if ($urandom_range(0, 7) == 0) ifc.btn_right = ~ifc.btn_right;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
